// File: rtl/seq_sub_311.sv
// seq_sub_311: sequential slice-serial subtractor producing d = x - y mod 2^WIDTH.
// Operands are latched on an accepted start and consumed SLICE bits per clock,
// LSB first, with the borrow carried between slices. The final borrow-out is b_311.
// Optional feature macro: SEQ_SUB_311_OVF_EN adds ovf_311 (signed overflow of x - y).
module seq_sub_311 #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk_311,
    input  logic             rst_n_311,
    input  logic             start_311,
    input  logic [WIDTH-1:0] x_311,
    input  logic [WIDTH-1:0] y_311,
    output logic             ready_311,
    output logic             done_311,
    output logic [WIDTH-1:0] d_311,
    output logic             b_311
`ifdef SEQ_SUB_311_OVF_EN
    ,
    output logic             ovf_311
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_next;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             last;
    logic [SLICE:0]   slice_res;

    // One slice of subtraction: {borrow_out, diff} = a - b - borrow_in.
    // The extra top bit goes to 1 exactly when the slice result is negative.
    function automatic logic [SLICE:0] sub_slice(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             bin
    );
        return {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
    endfunction

    assign accept    = (state_q == IDLE) && start_311;
    assign last      = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign slice_res = sub_slice(x_sh[SLICE-1:0], y_sh[SLICE-1:0], borrow_q);

    // The result register shifts right each slice; the fresh difference bits
    // enter at the top so after N slices slice 0 sits at the LSB.
    assign d_next = (d_q >> SLICE) | (WIDTH'(slice_res[SLICE-1:0]) << (WIDTH - SLICE));

    // State register; reset forces IDLE and aborts any operation in flight.
    always_ff @(posedge clk_311) begin
        if (!rst_n_311) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_311) state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output decode straight from the registered state.
    always_comb begin
        ready_311 = (state_q == IDLE);
        done_311  = (state_q == DONE);
    end

    // Control and result state: borrow, slice counter and difference register.
    always_ff @(posedge clk_311) begin
        if (!rst_n_311) begin
            d_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            d_q      <= d_next;
            borrow_q <= slice_res[SLICE];
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Operand shift registers: loaded on accept, shifted one slice per RUN edge.
    always_ff @(posedge clk_311) begin
        if (accept) begin
            x_sh <= x_311;
            y_sh <= y_311;
        end else if (state_q == RUN) begin
            x_sh <= x_sh >> SLICE;
            y_sh <= y_sh >> SLICE;
        end
    end

    assign d_311 = d_q;
    assign b_311 = borrow_q;

`ifdef SEQ_SUB_311_OVF_EN
    logic x_msb;
    logic y_msb;
    logic ovf_q;

    // Operand signs are kept aside because the shift registers lose them.
    always_ff @(posedge clk_311) begin
        if (accept) begin
            x_msb <= x_311[WIDTH-1];
            y_msb <= y_311[WIDTH-1];
        end
    end

    // Overflow resolved on the final slice: signs differ and result sign flips from x.
    always_ff @(posedge clk_311) begin
        if (!rst_n_311) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= (x_msb ^ y_msb) & (d_next[WIDTH-1] ^ x_msb);
        end
    end

    assign ovf_311 = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub_311.sv
// Testbench for seq_sub_311: an 8-bit/1-bit-slice instance and a 16-bit/4-bit-slice instance.
module tb_seq_sub_311;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  x8, y8, d8;
    logic        rdy8, done8, b8;
    logic [15:0] x16, y16, d16;
    logic        rdy16, done16, b16;
`ifdef SEQ_SUB_311_OVF_EN
    logic        ovf8, ovf16;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        b;
        logic        o;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_sub_311 #(.WIDTH(8), .SLICE(1)) u8 (
        .clk_311   (clk),
        .rst_n_311 (rst_n),
        .start_311 (start8),
        .x_311     (x8),
        .y_311     (y8),
        .ready_311 (rdy8),
        .done_311  (done8),
        .d_311     (d8),
        .b_311     (b8)
`ifdef SEQ_SUB_311_OVF_EN
        ,
        .ovf_311   (ovf8)
`endif
    );

    seq_sub_311 #(.WIDTH(16), .SLICE(4)) u16 (
        .clk_311   (clk),
        .rst_n_311 (rst_n),
        .start_311 (start16),
        .x_311     (x16),
        .y_311     (y16),
        .ready_311 (rdy16),
        .done_311  (done16),
        .d_311     (d16),
        .b_311     (b16)
`ifdef SEQ_SUB_311_OVF_EN
        ,
        .ovf_311   (ovf16)
`endif
    );

    // Reference: whole-word subtraction, unsigned compare for borrow, sign rule for overflow.
    function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [15:0] mask;
        mask = (w == 16) ? 16'hFFFF : 16'((1 << w) - 1);
        e.d  = (x - y) & mask;
        e.b  = (x < y);
        e.o  = (x[w-1] != y[w-1]) && (e.d[w-1] != x[w-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
        x8 = '0; y8 = '0; x16 = '0; y16 = '0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if (rdy8 !== 1'b1 || done8 !== 1'b0) begin n_err++; $display("FAIL reset8_ctl: ready=%b done=%b want 1 0", rdy8, done8); end
        n_cmp++; if (d8 !== 8'h00 || b8 !== 1'b0) begin n_err++; $display("FAIL reset8_data: d=%h b=%b want 00 0", d8, b8); end
        n_cmp++; if (rdy16 !== 1'b1 || done16 !== 1'b0 || d16 !== 16'h0 || b16 !== 1'b0) begin n_err++; $display("FAIL reset16: ready=%b done=%b d=%h b=%b want 1 0 0000 0", rdy16, done16, d16, b16); end
`ifdef SEQ_SUB_311_OVF_EN
        n_cmp++; if (ovf8 !== 1'b0 || ovf16 !== 1'b0) begin n_err++; $display("FAIL reset_ovf: ovf8=%b ovf16=%b want 0 0", ovf8, ovf16); end
`endif
        // Abort mid-RUN: accept, run two slices, then hold reset for two edges.
        x8 = 8'h00; y8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        seen = 0;
        rst_n = 1'b0; start8 = 1'b1;
        tick(); if (done8) seen++;
        tick(); if (done8) seen++;
        rst_n = 1'b1; start8 = 1'b0;
        n_cmp++; if (d8 !== 8'h00 || b8 !== 1'b0 || rdy8 !== 1'b1) begin n_err++; $display("FAIL reset_midrun: d=%h b=%b ready=%b want 00 0 1", d8, b8, rdy8); end
        for (int i = 0; i < 12; i++) begin tick(); if (done8) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL reset_nodone: done pulses=%0d want 0", seen); end
    endtask

    task automatic test_basic8();
        exp_t e;
        int   lat;
        x8 = 8'h5A; y8 = 8'h13; start8 = 1'b1;
        q8.push_back(model(8, 16'(x8), 16'(y8)));
        tick();
        start8 = 1'b0; x8 = 8'hEE; y8 = 8'h77;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin tick(); if (done8) lat = i; end
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL basic8_latency: got %0d want 8", lat); end
        e = q8.pop_front();
        n_cmp++; if (d8 !== e.d[7:0] || b8 !== e.b) begin n_err++; $display("FAIL basic8_result: d=%h b=%b want %h %b", d8, b8, e.d[7:0], e.b); end
        tick();
        n_cmp++; if (done8 !== 1'b0 || rdy8 !== 1'b1 || d8 !== e.d[7:0] || b8 !== e.b) begin n_err++; $display("FAIL basic8_hold: done=%b ready=%b d=%h b=%b want 0 1 %h %b", done8, rdy8, d8, b8, e.d[7:0], e.b); end
    endtask

    task automatic test_wrap();
        logic [7:0] tx[4] = '{8'h00, 8'h80, 8'h3C, 8'h01};
        logic [7:0] ty[4] = '{8'h01, 8'h01, 8'h3C, 8'hFF};
        exp_t e;
        int   got;
        for (int k = 0; k < 4; k++) begin
            x8 = tx[k]; y8 = ty[k]; start8 = 1'b1;
            q8.push_back(model(8, 16'(x8), 16'(y8)));
            tick();
            start8 = 1'b0;
            got = 0;
            for (int i = 0; i < 20 && got == 0; i++) begin tick(); if (done8) got = 1; end
            e = q8.pop_front();
            n_cmp++;
            if (got == 0) begin n_err++; $display("FAIL wrap_timeout: case %0d no done", k); end
            else if (d8 !== e.d[7:0] || b8 !== e.b) begin n_err++; $display("FAIL wrap_result: case %0d d=%h b=%b want %h %b", k, d8, b8, e.d[7:0], e.b); end
`ifdef SEQ_SUB_311_OVF_EN
            n_cmp++; if (ovf8 !== e.o) begin n_err++; $display("FAIL wrap_ovf: case %0d ovf=%b want %b", k, ovf8, e.o); end
`endif
            tick();
        end
    endtask

    task automatic test_slice4();
        exp_t e;
        int   lat;
        x16 = 16'h1234; y16 = 16'h4321; start16 = 1'b1;
        q16.push_back(model(16, x16, y16));
        tick();
        start16 = 1'b0; x16 = 16'hFFFF; y16 = 16'h0000;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin tick(); if (done16) lat = i; end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL slice4_latency: got %0d want 4", lat); end
        e = q16.pop_front();
        n_cmp++; if (d16 !== e.d || b16 !== e.b) begin n_err++; $display("FAIL slice4_result: d=%h b=%b want %h %b", d16, b16, e.d, e.b); end
`ifdef SEQ_SUB_311_OVF_EN
        n_cmp++; if (ovf16 !== e.o) begin n_err++; $display("FAIL slice4_ovf: ovf=%b want %b", ovf16, e.o); end
`endif
        tick();
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   lat;
        int   extra;
        x8 = 8'hC3; y8 = 8'h5A; start8 = 1'b1;
        q8.push_back(model(8, 16'(x8), 16'(y8)));
        tick();
        start8 = 1'b0;
        tick(); tick();
        x8 = 8'h11; y8 = 8'h22; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        for (int i = 4; i <= 20 && lat == 0; i++) begin tick(); if (done8) lat = i; end
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL ignore_latency: got %0d want 8", lat); end
        e = q8.pop_front();
        n_cmp++; if (d8 !== e.d[7:0] || b8 !== e.b) begin n_err++; $display("FAIL ignore_result: d=%h b=%b want %h %b", d8, b8, e.d[7:0], e.b); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (done8) extra++; end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ignore_extra_done: pulses=%0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ndone;
        int   last_cyc;
        ndone = 0; last_cyc = -1;
        start8 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (done8) begin
                ndone++;
                n_cmp++;
                if (q8.size() == 0) begin n_err++; $display("FAIL b2b_unexpected: done at cycle %0d with empty queue", c); end
                else begin
                    e = q8.pop_front();
                    if (d8 !== e.d[7:0] || b8 !== e.b) begin n_err++; $display("FAIL b2b_result: cycle %0d d=%h b=%b want %h %b", c, d8, b8, e.d[7:0], e.b); end
                end
                if (last_cyc >= 0) begin
                    n_cmp++; if (c - last_cyc !== 10) begin n_err++; $display("FAIL b2b_spacing: got %0d want 10", c - last_cyc); end
                end
                last_cyc = c;
            end
            if (c >= 30) start8 = 1'b0;
            x8 = 8'($urandom); y8 = 8'($urandom);
            if (start8 && rdy8) q8.push_back(model(8, 16'(x8), 16'(y8)));
            if (c >= 30 && q8.size() == 0 && !done8) break;
            tick();
        end
        n_cmp++; if (ndone !== 3 || q8.size() !== 0) begin n_err++; $display("FAIL b2b_count: done=%0d pending=%0d want 3 0", ndone, q8.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic8();
        test_wrap();
        test_slice4();
        test_ignore_start();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_sub_311.md
SEQ_SUB_311 -- requirements
Module: seq_sub_311

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal: 2..64).
REQ-002 SHALL have parameter SLICE, default 1, meaning bits subtracted per clock (legal: 1..WIDTH, WIDTH divisible by SLICE).
REQ-003 SHALL have port clk_311  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n_311  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_311  input  1  request to begin one subtraction.
REQ-006 SHALL have port x_311  input  WIDTH  minuend, sampled on accepted start.
REQ-007 SHALL have port y_311  input  WIDTH  subtrahend, sampled on accepted start.
REQ-008 SHALL have port ready_311  output  1  high when a start will be accepted.
REQ-009 SHALL have port done_311  output  1  one-cycle pulse when the result is complete.
REQ-010 SHALL have port d_311  output  WIDTH  difference x-y modulo 2^WIDTH.
REQ-011 SHALL have port b_311  output  1  final borrow-out (1 when x<y, unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; ready_311 high only in IDLE.
REQ-013 SHALL, in IDLE with start_311=1 at an edge, latch x_311/y_311, clear internal borrow to 0, clear slice counter, go to RUN.
REQ-014 SHALL, at each edge in RUN, subtract the next SLICE bits LSB-first with borrow-in from the previous slice, store difference bits into d_311 and the new borrow.
REQ-015 SHALL leave RUN after exactly N=WIDTH/SLICE RUN edges and enter DONE; done_311 high for exactly the one cycle spent in DONE; DONE returns to IDLE next edge unconditionally.
REQ-016 SHALL give latency: start sampled at edge k -> done_311 high between edges k+N and k+N+1 (WIDTH=8, SLICE=1 -> 8 edges).
REQ-017 SHALL drive b_311 with borrow-out of the most significant slice; d_311/b_311 held stable from DONE until the next accepted start.
REQ-018 SHALL ignore start_311 in RUN and DONE (no restart, operands not re-sampled); input changes of x_311/y_311 after acceptance SHALL not affect the result.
REQ-019 SHALL accept back-to-back operations: start held high continuously yields one operation every N+2 cycles.
REQ-020 SHALL produce d_311 = 0, b_311 = 0 for x=y, and d_311 = 2^WIDTH-1, b_311 = 1 for x=0, y=1 (wrap-around).

Reset
REQ-021 SHALL, while rst_n_311=0 at an edge, force state IDLE, d_311=0, b_311=0, done_311=0, internal borrow and counter to 0; ready_311=1 after the edge.
REQ-022 SHALL abort any operation in progress on reset mid-RUN or in DONE with no done_311 pulse; reset takes priority over start_311.

Configuration
REQ-023 SHALL, when macro SEQ_SUB_311_OVF_EN is defined, add output port ovf_311 (1 bit) = signed two's-complement overflow of x-y (operand signs differ and result sign differs from x sign), valid and held with d_311, reset to 0.
REQ-024 SHALL, when SEQ_SUB_311_OVF_EN is undefined, have no ovf_311 port and no overflow logic; all other behaviour identical.

Verification
REQ-025 Reset: rst_n_311=0 for 2 edges mid-RUN -> no done_311, d_311=0, b_311=0, ready_311=1 after release.
REQ-026 WIDTH=8, SLICE=1: x=0x5A, y=0x13, start at edge 0 -> done_311 high after edge 8 only, d_311=0x47, b_311=0.
REQ-027 WIDTH=8, SLICE=1: x=0x00, y=0x01 -> d_311=0xFF, b_311=1; then x=0x80, y=0x01 with SEQ_SUB_311_OVF_EN -> d_311=0x7F, b_311=0, ovf_311=1.
REQ-028 WIDTH=16, SLICE=4: x=0x1234, y=0x4321 -> done after 4 edges, d_311=0xCF13, b_311=1.
REQ-029 start_311 pulsed again at RUN edge 3 with new operands -> ignored, result of first operation unchanged, single done_311 pulse.
REQ-030 start_311 held high for 30 cycles, WIDTH=8, SLICE=1 -> done_311 pulses every 10 cycles, each result matching operands present at its accept edge.
